// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and default width.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Latency: combinational. Backpressure: none.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   pr_in,
  input  logic [WIDTH-1:0] dq_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   pr_out,
  output logic [WIDTH-2:0] dq_shift,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The top bit of diff is the borrow: clear means the divisor fit.
  always_comb begin
    shifted  = {pr_in, dq_in[WIDTH-1]};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[WIDTH+1];
    pr_out   = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    dq_shift = dq_in[WIDTH-2:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned divider, one quotient bit per cycle.
// Latency: WIDTH+2 cycles start-to-done (2 for b == 0). Backpressure: start ignored while busy.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] b_mag;
  logic             sign_r;
  logic             q_neg;
  logic             r_neg;
  logic             b_zero;

  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic [WIDTH:0]   pr_next;
  logic [WIDTH-2:0] dq_shift;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_src;
  logic [WIDTH-1:0] r_fix;

  assign a_mag_in = (sign && a[WIDTH-1]) ? -a : a;
  assign b_mag_in = (sign && b[WIDTH-1]) ? -b : b;
  assign busy     = (state != ST_IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr_in    (pr),
    .dq_in    (dq),
    .divisor  (b_mag),
    .pr_out   (pr_next),
    .dq_shift (dq_shift),
    .q_bit    (q_bit)
  );

  // On b == 0 dq still holds |a|; re-applying the dividend sign restores a exactly.
  always_comb begin
    r_src = b_zero ? dq : pr[WIDTH-1:0];
    r_fix = (sign_r && r_neg) ? -r_src : r_src;
    if (b_zero)
      q_fix = '1;
    else
      q_fix = (sign_r && q_neg) ? -dq : dq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pr        <= '0;
      dq        <= '0;
      b_mag     <= '0;
      sign_r    <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      b_zero    <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cnt    <= '0;
              pr     <= '0;
              dq     <= a_mag_in;
              b_mag  <= b_mag_in;
              sign_r <= sign;
              q_neg  <= (a[WIDTH-1] ^ b[WIDTH-1]) & sign;
              r_neg  <= a[WIDTH-1] & sign;
              b_zero <= (b == '0);
              state  <= (b == '0) ? ST_FIX : ST_CALC;
            end
          end
          ST_CALC: begin
            pr  <= pr_next;
            dq  <= {dq_shift, q_bit};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1))
              state <= ST_FIX;
          end
          ST_FIX: begin
            quotient  <= q_fix;
            remainder <= r_fix;
            div_zero  <= b_zero;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width; legal values are 8 to 64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), SHALL set the iteration counter width.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request; sampled only while idle.
REQ-006 sign  in  1  1 = signed two's-complement divide, 0 = unsigned; sampled with start.
REQ-007 cancel  in  1  abort the current operation (pipeline flush or exception).
REQ-008 a  in  WIDTH  dividend; sampled with start.
REQ-009 b  in  WIDTH  divisor; sampled with start.
REQ-010 busy  out  1  high while an operation is in progress.
REQ-011 done  out  1  one-cycle pulse; results are valid in that cycle.
REQ-012 quotient  out  WIDTH  registered quotient, held until the next done.
REQ-013 remainder  out  WIDTH  registered remainder, held until the next done.
REQ-014 div_zero  out  1  registered flag: the last completed operation had b == 0.

Function
REQ-015 The state machine SHALL have three states: IDLE, CALC and FIX.
REQ-016 In IDLE, start=1 with cancel=0 SHALL, on that edge, latch the magnitudes of a and b, latch sign, latch the quotient sign (a[MSB]^b[MSB])&sign and the remainder sign a[MSB]&sign, and go to CALC (or to FIX if b == 0).
REQ-017 In unsigned mode, the magnitude of each operand SHALL be the operand itself; in signed mode, a negative operand SHALL be two's-complement negated, computed at WIDTH bits.
REQ-018 In CALC, the block SHALL perform one restoring shift-subtract iteration per cycle for exactly WIDTH cycles, using a WIDTH+1-bit partial remainder, then go to FIX.
REQ-019 In FIX, the block SHALL apply sign correction, write quotient, remainder and div_zero, assert done on the next cycle, and return to IDLE.
REQ-020 Latency: if start is accepted in cycle 0, done SHALL be high in cycle WIDTH+2; for b == 0, done SHALL be high in cycle 2.
REQ-021 busy SHALL be high exactly in the CALC and FIX cycles, and SHALL be low in the done cycle.
REQ-022 A start in the done cycle SHALL be accepted, giving back-to-back operation.
REQ-023 start while busy SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-024 Divide by zero SHALL give quotient = all ones, remainder = a (unmodified), and div_zero = 1; any other completion SHALL clear div_zero.
REQ-025 Signed overflow (most-negative value / -1) SHALL give quotient = most-negative value and remainder = 0, with no flag.
REQ-026 The remainder sign SHALL follow the dividend; the quotient SHALL truncate toward zero.
REQ-027 cancel=1 in any state SHALL force IDLE on the next edge, with no done pulse and no change to quotient, remainder or div_zero.
REQ-028 cancel=1 together with start in IDLE: cancel SHALL win and the start SHALL be dropped.

Reset
REQ-029 rst SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, and counter=0.
REQ-030 rst mid-operation SHALL discard the operation, with no done pulse.
REQ-031 rst SHALL take priority over start and cancel.

Structure
REQ-032 The state encoding (IDLE/CALC/FIX) and DIV_WIDTH_DEFAULT=32 SHALL reside in the shared package div_pkg.
REQ-033 A combinational sub-module div_step SHALL perform one restoring iteration: {partial remainder, dividend shift} in, next values plus quotient bit out; it SHALL be parametrised by WIDTH.
REQ-034 Sign correction and the operand-magnitude logic SHALL remain in div_seq.

Verification (WIDTH=32)
REQ-035 sign=0, a=100, b=7, start in cycle 0 -> done in cycle 34, quotient=14, remainder=2, busy high in cycles 1-33.
REQ-036 sign=1, a=-100 (0xFFFFFF9C), b=7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
REQ-037 sign=1, a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_zero=0.
REQ-038 sign=0, a=0x1234, b=0 -> done in cycle 2, quotient=0xFFFFFFFF, remainder=0x1234, div_zero=1.
REQ-039 Cancel: start (sign=0, a=50, b=5), cancel in cycle 10 -> no done ever, busy low from cycle 11, outputs keep their previous values; a new start in cycle 11 completes normally with quotient=10.
REQ-040 Back-to-back: a second start (sign=0, a=9, b=3) issued in the done cycle of the REQ-035 operation -> second done 34 cycles later, quotient=3, remainder=0; and rst in cycle 5 of any operation -> no done, all outputs 0.
